// File: rtl/dm_banked_ctrl.sv
// dm_banked_ctrl
// Data memory for the MEM stage of a pipelined MIPS core. It supports
// byte, half and word loads and stores (lb/lbu/lh/lhu/sb/sh/sw) behind a
// req/ready/ack handshake, with a configurable number of wait states.
// The core is a 32-bit wide RAM with 4 little-endian byte lanes. Read data
// is registered.
//
// Optional feature: define DM_MISALIGN_TRAP_EN to trap misaligned accesses.
//   Defined   : a misaligned access completes with dm_err=1, its write is
//               dropped and data_out keeps its value.
//   Undefined : dm_err is tied to 0. The address is force-aligned for its
//               size and the access goes ahead.
//
// Parameters
//   ADDR_WIDTH   word-address bits (1..29); depth is 2**ADDR_WIDTH words
//   WAIT_STATES  extra busy cycles per access (0..7)
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   dm_req        access request, sampled only while dm_ready=1
//   dm_ready      idle, a request can be accepted this cycle
//   data_address  byte address; bits [ADDR_WIDTH+1:2] select the word
//   dm_r, dm_w    read / write access (both set: write only, data_out held)
//   dm_size       00 byte, 01 half, 10/11 word
//   dm_sext       sign-extend sub-word loads
//   data_in       right-justified store data
//   data_out      extended load result, updated on read acks only
//   dm_ack        one-cycle completion pulse
//   dm_err        misaligned-access flag, valid with dm_ack
//
// Handshake: a request is taken on a rising edge where dm_ready=1,
// dm_req=1 and (dm_r|dm_w)=1. All request fields are captured on that
// edge. dm_ready then stays low until the cycle in which dm_ack pulses.
// In that ack cycle a new request can be accepted.
module dm_banked_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dm_req,
  output logic        dm_ready,
  input  logic [31:0] data_address,
  input  logic        dm_r,
  input  logic        dm_w,
  input  logic [1:0]  dm_size,
  input  logic        dm_sext,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        dm_ack,
  output logic        dm_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // BUSY is left when the counter reaches this value. The BUSY state
  // therefore lasts exactly WAIT_STATES cycles.
  localparam logic [2:0] WS_LAST = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  logic [1:0]            state;
  logic [2:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] a_idx;
  logic [1:0]            a_low;
  logic                  a_r;
  logic                  a_w;
  logic [1:0]            a_size;
  logic                  a_sext;
  logic [31:0]           a_data;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        misaligned;
  logic        trap;
  logic [1:0]  eff_low;
  logic [3:0]  byte_en;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;

  // Upper address bits beyond the RAM depth alias and are not used.
  logic unused_addr;
  assign unused_addr = ^data_address[31:ADDR_WIDTH+2];

  assign accept   = (state == S_IDLE) && dm_req && (dm_r || dm_w);
  assign dm_ready = (state == S_IDLE);

  // Alignment, lane selection and store-data replication for the
  // latched request. Size 11 behaves exactly like a word access.
  always_comb begin
    misaligned = 1'b0;
    eff_low    = 2'b00;
    byte_en    = 4'b1111;
    wr_data    = a_data;
    case (a_size)
      2'b00: begin
        eff_low = a_low;
        byte_en = 4'b0001 << a_low;
        wr_data = {4{a_data[7:0]}};
      end
      2'b01: begin
        misaligned = a_low[0];
        eff_low    = {a_low[1], 1'b0};
        byte_en    = a_low[1] ? 4'b1100 : 4'b0011;
        wr_data    = {2{a_data[15:0]}};
      end
      default: begin
        misaligned = (a_low != 2'b00);
      end
    endcase
  end

`ifdef DM_MISALIGN_TRAP_EN
  assign trap = misaligned;
`else
  assign trap = 1'b0;
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
`endif

  // A combined read+write request performs only the write.
  assign wr_en = (state == S_ACCESS) && a_w && !trap;
  assign rd_en = (state == S_ACCESS) && a_r && !a_w && !trap;

  // Load path: shift the addressed lane(s) down to bit 0, then extend.
  assign rd_word  = mem[a_idx];
  assign rd_shift = rd_word >> {eff_low, 3'b000};

  always_comb begin
    rd_ext = rd_word;
    case (a_size)
      2'b00:   rd_ext = {{24{a_sext & rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   rd_ext = {{16{a_sext & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_word;
    endcase
  end

  // RAM core, which has no reset. A write commits only on the ACCESS
  // edge. A reset mid-access forces IDLE, so the write never happens.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && byte_en[i]) begin
        mem[a_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Control FSM and request capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= 3'd0;
      a_idx    <= '0;
      a_low    <= 2'b00;
      a_r      <= 1'b0;
      a_w      <= 1'b0;
      a_size   <= 2'b00;
      a_sext   <= 1'b0;
      a_data   <= 32'd0;
      dm_ack   <= 1'b0;
      data_out <= 32'd0;
    end else begin
      dm_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_idx    <= data_address[ADDR_WIDTH+1:2];
            a_low    <= data_address[1:0];
            a_r      <= dm_r;
            a_w      <= dm_w;
            a_size   <= dm_size;
            a_sext   <= dm_sext;
            a_data   <= data_in;
            wait_cnt <= 3'd0;
            state    <= (WAIT_STATES == 0) ? S_ACCESS : S_BUSY;
          end
        end
        S_BUSY: begin
          if (wait_cnt == WS_LAST) begin
            state <= S_ACCESS;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        S_ACCESS: begin
          dm_ack <= 1'b1;
          state  <= S_IDLE;
          if (rd_en) begin
            data_out <= rd_ext;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DM_MISALIGN_TRAP_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state == S_ACCESS) && trap;
    end
  end
  assign dm_err = err_q;
`else
  assign dm_err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_banked_ctrl.sv
// Testbench for dm_banked_ctrl.
// It builds three instances with WAIT_STATES 0, 3 and 2, and exercises
// them one after another.
// Each expected ack response ({err, data_out}) is queued when its request
// is issued. A monitor pops the queue and compares whenever any instance
// pulses dm_ack.
module tb_dm_banked_ctrl;

  localparam int WS_TAB [3] = '{0, 3, 2};

  logic        clk;
  logic        rst_n;
  logic        req   [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [1:0]  size  [3];
  logic        sext  [3];
  logic [31:0] addr  [3];
  logic [31:0] din   [3];
  logic [31:0] dout  [3];
  logic        ready [3];
  logic        ack   [3];
  logic        err   [3];

  logic [32:0] exp_q [$];
  string       name_q [$];
  int          checks;
  int          failures;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dm_banked_ctrl #(.ADDR_WIDTH(10), .WAIT_STATES(WS_TAB[g])) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dm_req       (req[g]),
      .dm_ready     (ready[g]),
      .data_address (addr[g]),
      .dm_r         (rd[g]),
      .dm_w         (wr[g]),
      .dm_size      (size[g]),
      .dm_sext      (sext[g]),
      .data_in      (din[g]),
      .data_out     (dout[g]),
      .dm_ack       (ack[g]),
      .dm_err       (err[g])
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp_v);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ack[k] === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack inst%0d: got ack with empty queue, expected none", k);
        end else begin
          logic [32:0] e;
          string       nm;
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check({nm, "_data"}, dout[k], e[31:0]);
          check({nm, "_err"}, {31'd0, err[k]}, {31'd0, e[32]});
        end
      end
    end
  end

  // Driver: waits (bounded) for ready, presents one request, and
  // measures accept-to-ack latency. Call it at #1 after a rising edge.
  // With hold=1, the request stays asserted afterwards so the next call
  // can be accepted in the ack cycle.
  task automatic access(input int k, input string nm, input logic r_i, input logic w_i,
                        input logic [1:0] sz, input logic sx, input logic [31:0] ad,
                        input logic [31:0] dt, input logic [31:0] exp_d, input logic exp_e,
                        input bit hold);
    int guard;
    int cyc;
    guard = 0;
    while (ready[k] !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      failures++;
      $display("FAIL %s_ready_timeout: got ready=0 expected ready=1", nm);
    end
    exp_q.push_back({exp_e, exp_d});
    name_q.push_back(nm);
    req[k] = 1'b1; rd[k] = r_i; wr[k] = w_i; size[k] = sz; sext[k] = sx;
    addr[k] = ad; din[k] = dt;
    @(posedge clk); #1;
    if (!hold) begin
      // These fields must have been latched on the accept edge.
      req[k] = 1'b0; rd[k] = ~r_i; wr[k] = ~w_i; size[k] = ~sz; sext[k] = ~sx;
      addr[k] = ~ad; din[k] = ~dt;
    end
    cyc = 0;
    while (ack[k] !== 1'b1 && cyc < 40) begin
      check({nm, "_ready_busy"}, {31'd0, ready[k]}, 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, "_latency"}, cyc, 32'(1 + WS_TAB[k]));
    check({nm, "_ready_at_ack"}, {31'd0, ready[k]}, 32'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0; size[k] = 2'b00; sext[k] = 1'b0;
      addr[k] = 32'd0; din[k] = 32'd0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_ready%0d", k), {31'd0, ready[k]}, 32'd1);
      check($sformatf("reset_ack%0d", k),   {31'd0, ack[k]},   32'd0);
      check($sformatf("reset_err%0d", k),   {31'd0, err[k]},   32'd0);
      check($sformatf("reset_dout%0d", k),  dout[k],           32'd0);
    end

    // Instance 0, WAIT_STATES=0
    access(0, "sw_10",   0, 1, 2'b10, 0, 32'h10,   32'hDEADBEEF, 32'h00000000, 0, 0);
    access(0, "lw_10",   1, 0, 2'b10, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 0);
    access(0, "sw0_10",  0, 1, 2'b10, 0, 32'h10,   32'h00000000, 32'hDEADBEEF, 0, 0);
    access(0, "sb_13",   0, 1, 2'b00, 0, 32'h13,   32'h12345680, 32'hDEADBEEF, 0, 0);
    access(0, "lb_13",   1, 0, 2'b00, 1, 32'h13,   32'h0,        32'hFFFFFF80, 0, 0);
    access(0, "lbu_13",  1, 0, 2'b00, 0, 32'h13,   32'h0,        32'h00000080, 0, 0);
    access(0, "lw_10b",  1, 0, 2'b10, 0, 32'h10,   32'h0,        32'h80000000, 0, 0);
    access(0, "lb_alias",1, 0, 2'b00, 1, 32'h1013, 32'h0,        32'hFFFFFF80, 0, 0);
    access(0, "sw_20",   0, 1, 2'b10, 0, 32'h20,   32'hAAAABBBB, 32'hFFFFFF80, 0, 0);
    access(0, "sh_22",   0, 1, 2'b01, 0, 32'h22,   32'h55551234, 32'hFFFFFF80, 0, 0);
    access(0, "lh_22",   1, 0, 2'b01, 1, 32'h22,   32'h0,        32'h00001234, 0, 0);
    access(0, "lw_20",   1, 0, 2'b10, 0, 32'h20,   32'h0,        32'h1234BBBB, 0, 0);
    access(0, "lbu_22",  1, 0, 2'b00, 0, 32'h22,   32'h0,        32'h00000034, 0, 0);
    access(0, "sw_24",   0, 1, 2'b10, 0, 32'h24,   32'h0000F00F, 32'h00000034, 0, 0);
    access(0, "lh_24",   1, 0, 2'b01, 1, 32'h24,   32'h0,        32'hFFFFF00F, 0, 0);
    access(0, "lhu_24",  1, 0, 2'b01, 0, 32'h24,   32'h0,        32'h0000F00F, 0, 0);
    access(0, "rw_30",   1, 1, 2'b10, 0, 32'h30,   32'h55AA55AA, 32'h0000F00F, 0, 0);
    access(0, "lw_30",   1, 0, 2'b10, 0, 32'h30,   32'h0,        32'h55AA55AA, 0, 0);
`ifdef DM_MISALIGN_TRAP_EN
    access(0, "mis_lw_11", 1, 0, 2'b10, 0, 32'h11, 32'h0,        32'h55AA55AA, 1, 0);
    access(0, "mis_sw_11", 0, 1, 2'b10, 0, 32'h11, 32'hCAFEF00D, 32'h55AA55AA, 1, 0);
    access(0, "lw_10c",    1, 0, 2'b10, 0, 32'h10, 32'h0,        32'h80000000, 0, 0);
    access(0, "mis_lh_23", 1, 0, 2'b01, 1, 32'h23, 32'h0,        32'h80000000, 1, 0);
`else
    access(0, "mis_lw_11", 1, 0, 2'b10, 0, 32'h11, 32'h0,        32'h80000000, 0, 0);
    access(0, "mis_sw_11", 0, 1, 2'b10, 0, 32'h11, 32'hCAFEF00D, 32'h80000000, 0, 0);
    access(0, "lw_10c",    1, 0, 2'b10, 0, 32'h10, 32'h0,        32'hCAFEF00D, 0, 0);
    access(0, "mis_lh_23", 1, 0, 2'b01, 1, 32'h23, 32'h0,        32'h00001234, 0, 0);
`endif

    // A request with neither read nor write must be ignored.
    req[0] = 1'b1; rd[0] = 1'b0; wr[0] = 1'b0; addr[0] = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("noop_ready", {31'd0, ready[0]}, 32'd1);
      check("noop_ack",   {31'd0, ack[0]},   32'd0);
    end
    req[0] = 1'b0;

    // Instance 1, WAIT_STATES=3: held request, then back-to-back accept in the ack cycle.
    access(1, "ws3_sw_08", 0, 1, 2'b10, 0, 32'h08, 32'h11223344, 32'h00000000, 0, 1);
    check("ws3_req_held", {31'd0, req[1]}, 32'd1);
    access(1, "ws3_lw_08", 1, 0, 2'b10, 0, 32'h08, 32'h0,        32'h11223344, 0, 0);

    // Instance 2, WAIT_STATES=2: reset in the middle of a write.
    access(2, "ws2_sw_40", 0, 1, 2'b10, 0, 32'h40, 32'h11112222, 32'h00000000, 0, 0);
    req[2] = 1'b1; rd[2] = 1'b0; wr[2] = 1'b1; size[2] = 2'b10; addr[2] = 32'h40;
    din[2] = 32'h99999999;
    @(posedge clk); #1;
    req[2] = 1'b0;
    check("rst_mid_busy_ready", {31'd0, ready[2]}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", {31'd0, ready[2]}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_mid_ack", {31'd0, ack[2]}, 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_after_ack",   {31'd0, ack[2]},   32'd0);
    check("rst_after_ready", {31'd0, ready[2]}, 32'd1);
    check("rst_after_dout",  dout[2],           32'd0);
    access(2, "ws2_lw_40", 1, 0, 2'b10, 0, 32'h40, 32'h0, 32'h11112222, 0, 0);

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
